// File: rtl/exe_issue_ctrl_pkg.sv
// Shared encodings for the I-type execute controller.
// Holds the opcode/funct3 codes, the zero constants, the FSM states and the step clamp.
package exe_issue_ctrl_pkg;

  localparam int unsigned SHAMT_WIDTH = 5;

  localparam logic [6:0] INST_TYPE_I        = 7'b0010011;
  localparam logic [2:0] INST_ADDI          = 3'b000;
  localparam logic [2:0] INST_SLLI          = 3'b001;
  localparam logic [2:0] INST_SLTI          = 3'b010;
  localparam logic [2:0] INST_SLTIU         = 3'b011;
  localparam logic [2:0] INST_XORI          = 3'b100;
  localparam logic [2:0] INST_SRLI_AND_SRAI = 3'b101;
  localparam logic [2:0] INST_ORI           = 3'b110;
  localparam logic [2:0] INST_ANDI          = 3'b111;

  localparam logic [31:0] ZERO          = 32'h0;
  localparam logic [4:0]  ZERO_REG      = 5'h0;
  localparam logic        WRITE_DISABLE = 1'b0;

  typedef enum logic {
    EXE_ST_IDLE  = 1'b0,
    EXE_ST_SHIFT = 1'b1
  } exe_state_e;

  // Positions to shift this cycle: the remaining count, capped at the step size.
  function automatic logic [SHAMT_WIDTH-1:0] clamp_step(input logic [SHAMT_WIDTH-1:0] rem,
                                                         input logic [SHAMT_WIDTH-1:0] step);
    return (rem > step) ? step : rem;
  endfunction

endpackage

// File: rtl/exe_issue_ctrl_iter_shift_step.sv
// Combinational partial shifter: moves value by a small amount, filling vacated bits with fill_i.
// dir_i = 1 shifts right, dir_i = 0 shifts left.
module iter_shift_step #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AMT_WIDTH  = 3
) (
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic [AMT_WIDTH-1:0]  amount_i,
  input  logic                  dir_i,
  input  logic                  fill_i,
  output logic [DATA_WIDTH-1:0] value_o
);

  always_comb begin
    value_o = '0;
    if (dir_i) begin
      value_o = DATA_WIDTH'({{DATA_WIDTH{fill_i}}, value_i} >> amount_i);
    end else begin
      value_o = DATA_WIDTH'(({value_i, {DATA_WIDTH{fill_i}}} << amount_i) >> DATA_WIDTH);
    end
  end

endmodule

// File: rtl/exe_issue_ctrl.sv
// I-type ALU execute controller: single-cycle ALU ops, iterative shifts through a step shifter,
// registered writeback pulse, flush and async reset abort.
module exe_issue_ctrl
  import exe_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned SHIFT_STEP  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            inst_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   busy_o
);

  localparam int unsigned AMT_WIDTH = $clog2(SHIFT_STEP + 1);

  exe_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] rem_q, rem_d;
  logic                   dir_q, dir_d;
  logic                   fill_q, fill_d;
  logic                   we_q, we_d;
  logic [RADDR_WIDTH-1:0] rd_q, rd_d;
  logic                   out_valid_q, out_valid_d;
  logic                   reg_we_q, reg_we_d;
  logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [DATA_WIDTH-1:0]  reg_wdata_q, reg_wdata_d;

  logic [6:0]             opcode_c;
  logic [2:0]             funct3_c;
  logic [SHAMT_WIDTH-1:0] shamt_c;
  logic                   accept_c;
  logic [SHAMT_WIDTH-1:0] step_amt_c;
  logic [DATA_WIDTH-1:0]  shift_out_c;
  logic                   inst_unused_c;

  assign opcode_c      = inst_i[6:0];
  assign funct3_c      = inst_i[14:12];
  assign shamt_c       = inst_i[24:20];
  assign inst_unused_c = ^{inst_i[31], inst_i[29:25], inst_i[19:15], inst_i[11:7]};

  // Ready depends only on state and reset, never on in_valid_i.
  assign in_ready_o = (state_q == EXE_ST_IDLE) & ~rst_i;
  assign accept_c   = in_valid_i & in_ready_o & ~flush_i;
  assign step_amt_c = clamp_step(rem_q, SHAMT_WIDTH'(SHIFT_STEP));

  iter_shift_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .AMT_WIDTH (AMT_WIDTH)
  ) u_shift_step (
    .value_i (acc_q),
    .amount_i(AMT_WIDTH'(step_amt_c)),
    .dir_i   (dir_q),
    .fill_i  (fill_q),
    .value_o (shift_out_c)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    fill_d      = fill_q;
    we_d        = we_q;
    rd_d        = rd_q;
    out_valid_d = 1'b0;
    reg_we_d    = WRITE_DISABLE;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;

    case (state_q)
      EXE_ST_IDLE: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          reg_we_d    = reg_we_i;
          reg_waddr_d = reg_waddr_i;
          if (opcode_c != INST_TYPE_I) begin
            reg_we_d    = WRITE_DISABLE;
            reg_waddr_d = RADDR_WIDTH'(ZERO_REG);
            reg_wdata_d = DATA_WIDTH'(ZERO);
          end else begin
            case (funct3_c)
              INST_ADDI:  reg_wdata_d = op1_i + op2_i;
              INST_SLTI:  reg_wdata_d = DATA_WIDTH'($signed(op1_i) < $signed(op2_i));
              INST_SLTIU: reg_wdata_d = DATA_WIDTH'(op1_i < op2_i);
              INST_XORI:  reg_wdata_d = op1_i ^ op2_i;
              INST_ORI:   reg_wdata_d = op1_i | op2_i;
              INST_ANDI:  reg_wdata_d = op1_i & op2_i;
              INST_SLLI, INST_SRLI_AND_SRAI: begin
                if (shamt_c == '0) begin
                  reg_wdata_d = op1_i;
                end else begin
                  // Latch the whole shift; the result pulse comes from SHIFT.
                  out_valid_d = 1'b0;
                  reg_we_d    = WRITE_DISABLE;
                  reg_waddr_d = reg_waddr_q;
                  acc_d       = op1_i;
                  rem_d       = shamt_c;
                  dir_d       = inst_i[14];
                  fill_d      = inst_i[14] & inst_i[30] & op1_i[DATA_WIDTH-1];
                  we_d        = reg_we_i;
                  rd_d        = reg_waddr_i;
                  state_d     = EXE_ST_SHIFT;
                end
              end
              default: begin
                reg_we_d    = WRITE_DISABLE;
                reg_waddr_d = RADDR_WIDTH'(ZERO_REG);
                reg_wdata_d = DATA_WIDTH'(ZERO);
              end
            endcase
          end
        end
      end

      EXE_ST_SHIFT: begin
        if (flush_i) begin
          state_d = EXE_ST_IDLE;
        end else begin
          acc_d = shift_out_c;
          rem_d = rem_q - step_amt_c;
          if (rem_d == '0) begin
            state_d     = EXE_ST_IDLE;
            out_valid_d = 1'b1;
            reg_we_d    = we_q;
            reg_waddr_d = rd_q;
            reg_wdata_d = shift_out_c;
          end
        end
      end

      default: state_d = EXE_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EXE_ST_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      fill_q      <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      fill_q      <= fill_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign busy_o      = (state_q == EXE_ST_SHIFT);

endmodule
